// File: rtl/crossbar_alloc_pkg.sv
// Shared index helpers for the crossbar allocator and its users.
// Request/grant slices omit the input's own port, so bit indices are remapped.
package crossbar_alloc_pkg;

  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int p_1(input int p);
    return p - 1;
  endfunction

  function automatic int pp_1(input int p);
    return p * (p - 1);
  endfunction

  // Output index -> bit position inside input in_idx's request slice.
  function automatic int req_bit(input int out_idx, input int in_idx);
    return (out_idx > in_idx) ? out_idx - 1 : out_idx;
  endfunction

  // Bit position inside input in_idx's slice -> output index.
  function automatic int out_of_bit(input int bit_idx, input int in_idx);
    return (bit_idx >= in_idx) ? bit_idx + 1 : bit_idx;
  endfunction

endpackage

// File: rtl/xbar_out_arbiter.sv
// Per-output wormhole arbiter: round-robin among head flits, lock until tail.
// Optional idle watchdog enabled by CROSSBAR_ALLOC_WATCHDOG_EN.
module xbar_out_arbiter
  import crossbar_alloc_pkg::*;
#(
  parameter int P            = 5,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [P-1:0] i_cand,
  input  logic [P-1:0] i_hdr,
  input  logic [P-1:0] i_tail,
  input  logic         i_ready,
  output logic [P-1:0] o_grant,
  output logic         o_locked,
  output logic         o_timeout
);

  localparam int IW = log2(P);

  logic          r_locked, w_locked_d;
  logic [IW-1:0] r_owner, w_owner_d;
  logic [IW-1:0] r_ptr, w_ptr_d;

  logic [P-1:0]  w_head;
  logic [P-1:0]  w_grant_raw;
  logic [IW-1:0] w_win;
  logic          w_found, w_win_tail;
  logic          w_own_req, w_own_tail;
  logic          w_granted;

  assign w_head = i_cand & i_hdr;

  always_comb begin
    w_win      = '0;
    w_found    = 1'b0;
    w_win_tail = 1'b0;
    for (int k = 0; k < P; k++) begin
      if (!w_found && w_head[(int'(r_ptr) + k) % P]) begin
        w_found    = 1'b1;
        w_win      = IW'((int'(r_ptr) + k) % P);
        w_win_tail = i_tail[(int'(r_ptr) + k) % P];
      end
    end
  end

  always_comb begin
    w_own_req  = 1'b0;
    w_own_tail = 1'b0;
    for (int j = 0; j < P; j++) begin
      if (IW'(j) == r_owner) begin
        w_own_req  = i_cand[j];
        w_own_tail = i_tail[j];
      end
    end
  end

  // A locked output serves only its owner, whatever flit type it presents.
  always_comb begin
    w_grant_raw = '0;
    if (r_locked) begin
      if (w_own_req && i_ready) w_grant_raw[r_owner] = 1'b1;
    end else if (w_found && i_ready) begin
      w_grant_raw[w_win] = 1'b1;
    end
  end

  assign o_grant   = reset ? w_grant_raw : '0;
  assign o_locked  = r_locked & reset;
  assign w_granted = |o_grant;

  always_comb begin
    w_locked_d = r_locked;
    w_owner_d  = r_owner;
    w_ptr_d    = r_ptr;
    if (!r_locked && w_granted) begin
      w_ptr_d = (w_win == IW'(P - 1)) ? '0 : w_win + IW'(1);
      if (!w_win_tail) begin
        w_locked_d = 1'b1;
        w_owner_d  = w_win;
      end
    end else if (r_locked && w_granted && w_own_tail) begin
      w_locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_locked <= 1'b0;
      r_owner  <= '0;
      r_ptr    <= '0;
    end else begin
      r_locked <= w_locked_d;
      r_owner  <= w_owner_d;
      r_ptr    <= w_ptr_d;
    end
  end

`ifdef CROSSBAR_ALLOC_WATCHDOG_EN
  localparam int CW = log2(LOCK_TIMEOUT + 1);

  logic [CW-1:0] r_idle_cnt, w_idle_cnt_d;
  logic          r_timeout;

  always_comb begin
    w_idle_cnt_d = r_idle_cnt;
    if (!r_locked || w_granted) begin
      w_idle_cnt_d = '0;
    end else if (r_idle_cnt != CW'(LOCK_TIMEOUT)) begin
      w_idle_cnt_d = r_idle_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_cnt_d;
      r_timeout  <= r_timeout | (w_idle_cnt_d == CW'(LOCK_TIMEOUT));
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(o_grant));

  for (genvar j = 0; j < P; j++) begin : g_chk
    // Body/tail flits may only cross on an output their packet already owns.
    a_body_needs_lock: assert property (@(posedge clk) disable iff (!reset)
      o_grant[j] |-> (i_hdr[j] || r_locked));
  end

endmodule

// File: rtl/crossbar_port_allocator.sv
// Wormhole output-port allocator driving the crossbar select bus.
// Define CROSSBAR_ALLOC_WATCHDOG_EN to build the per-output lock watchdog.
module crossbar_port_allocator
  import crossbar_alloc_pkg::*;
#(
  parameter int P            = 5,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [pp_1(P)-1:0]   req_all,
  input  logic [P-1:0]         hdr_flg_all,
  input  logic [P-1:0]         tail_flg_all,
  input  logic [P-1:0]         out_ready_all,
  output logic [pp_1(P)-1:0]   granted_dest_port_all,
  output logic [P-1:0]         in_grant_all,
  output logic [P-1:0]         out_locked_all,
  output logic [P-1:0]         lock_timeout_all
);

  localparam int P_1 = p_1(P);

  logic [P-1:0] w_cand      [P];
  logic [P-1:0] w_out_grant [P];
  logic [P-1:0] w_self_grant;

  for (genvar o = 0; o < P; o++) begin : g_out
    for (genvar j = 0; j < P; j++) begin : g_in
      if (j == o) begin : g_self
        assign w_cand[o][j] = 1'b0;
      end else begin : g_other
        assign w_cand[o][j] = req_all[j*P_1 + req_bit(o, j)];
      end
    end

    xbar_out_arbiter #(
      .P            (P),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_cand    (w_cand[o]),
      .i_hdr     (hdr_flg_all),
      .i_tail    (tail_flg_all),
      .i_ready   (out_ready_all[o]),
      .o_grant   (w_out_grant[o]),
      .o_locked  (out_locked_all[o]),
      .o_timeout (lock_timeout_all[o])
    );

    assign w_self_grant[o] = w_out_grant[o][o];
  end

  for (genvar j = 0; j < P; j++) begin : g_slice
    for (genvar b = 0; b < P_1; b++) begin : g_bit
      assign granted_dest_port_all[j*P_1 + b] = w_out_grant[out_of_bit(b, j)][j];
    end
    assign in_grant_all[j] = |granted_dest_port_all[j*P_1 +: P_1];

    a_req_onehot: assert property (@(posedge clk) disable iff (!reset)
      $onehot0(req_all[j*P_1 +: P_1]));
  end

  a_no_self_grant: assert property (@(posedge clk) disable iff (!reset) w_self_grant == '0);

endmodule
